// File: rtl/pwm_ramp_sequencer.sv
// Drives one pwm_gen: ramps its compare value toward a target in fixed steps,
// and applies every arr/compare change only on a PWM period boundary.
module pwm_ramp_sequencer #(
    parameter int CW = 32,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [CW-1:0] cfg_arr,
    input  logic [CW-1:0] cfg_target,
    input  logic [CW-1:0] cfg_step,
    input  logic [DW-1:0] cfg_hold,
    input  logic          stop_req,
    output logic          pwm_gen_en,
    output logic [CW-1:0] counter_arr,
    output logic [CW-1:0] counter_compare,
    output logic          period_tick,
    output logic          busy,
    output logic          done
);
    typedef enum logic [1:0] {IDLE, RAMP, HOLD, STOPPING} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] pcnt, pcnt_nxt, tgt, tgt_nxt, step, step_nxt;
    logic [DW-1:0] hold, hold_nxt, scnt, scnt_nxt;
    logic [CW-1:0] pend_arr, pend_arr_nxt, pend_tgt, pend_tgt_nxt, pend_step, pend_step_nxt;
    logic [DW-1:0] pend_hold, pend_hold_nxt;
    logic          pend_vld, pend_vld_nxt;
    logic          en_nxt, tick_nxt, done_nxt;
    logic [CW-1:0] arr_nxt, cmp_nxt;

    logic          accept, period_end;
    logic [CW-1:0] in_tgt, stepped;
    logic [DW-1:0] in_hold;
    logic [CW:0]   sum;
    logic [CW-1:0] src_arr, src_tgt, src_step, src_cmp;
    logic [DW-1:0] src_hold;

    assign cfg_ready  = (state == IDLE || state == HOLD) && !stop_req;
    assign accept     = cfg_valid && cfg_ready;
    // period_tick is registered from next-state values, so it equals the live period-end decode
    assign period_end = period_tick;
    assign in_tgt     = (cfg_target > cfg_arr) ? cfg_arr : cfg_target;
    assign in_hold    = (cfg_hold == '0) ? DW'(1) : cfg_hold;
    assign sum        = {1'b0, counter_compare} + {1'b0, step};

    always_comb begin
        if (step == '0)
            stepped = tgt;
        else if (counter_compare < tgt)
            stepped = (sum >= {1'b0, tgt}) ? tgt : sum[CW-1:0];
        else
            stepped = (step >= counter_compare - tgt) ? tgt : counter_compare - step;
    end

    // an accept landing on the boundary itself is applied directly, bypassing the pending slot
    assign src_arr  = accept ? cfg_arr  : pend_arr;
    assign src_tgt  = accept ? in_tgt   : pend_tgt;
    assign src_step = accept ? cfg_step : pend_step;
    assign src_hold = accept ? in_hold  : pend_hold;
    assign src_cmp  = (counter_compare > src_arr) ? src_arr : counter_compare;

    always_comb begin
        state_nxt     = state;
        en_nxt        = pwm_gen_en;
        arr_nxt       = counter_arr;
        cmp_nxt       = counter_compare;
        tgt_nxt       = tgt;
        step_nxt      = step;
        hold_nxt      = hold;
        scnt_nxt      = scnt;
        pend_vld_nxt  = pend_vld;
        pend_arr_nxt  = pend_arr;
        pend_tgt_nxt  = pend_tgt;
        pend_step_nxt = pend_step;
        pend_hold_nxt = pend_hold;
        done_nxt      = 1'b0;
        case (state)
            IDLE: if (accept) begin
                arr_nxt  = cfg_arr;
                cmp_nxt  = '0;
                en_nxt   = 1'b1;
                scnt_nxt = '0;
                tgt_nxt  = in_tgt;
                step_nxt = cfg_step;
                hold_nxt = in_hold;
                if (in_tgt == '0) begin
                    state_nxt = HOLD;
                    done_nxt  = 1'b1;
                end else begin
                    state_nxt = RAMP;
                end
            end
            RAMP, HOLD: if (stop_req) begin
                pend_vld_nxt = 1'b0;
                if (period_end) begin
                    en_nxt    = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = STOPPING;
                end
            end else if (state == RAMP) begin
                if (period_end) begin
                    if (scnt == hold - DW'(1)) begin
                        scnt_nxt = '0;
                        cmp_nxt  = stepped;
                        if (stepped == tgt) begin
                            state_nxt = HOLD;
                            done_nxt  = 1'b1;
                        end
                    end else begin
                        scnt_nxt = scnt + DW'(1);
                    end
                end
            end else begin
                if (accept) begin
                    pend_vld_nxt  = 1'b1;
                    pend_arr_nxt  = cfg_arr;
                    pend_tgt_nxt  = in_tgt;
                    pend_step_nxt = cfg_step;
                    pend_hold_nxt = in_hold;
                end
                if (period_end && (accept || pend_vld)) begin
                    pend_vld_nxt = 1'b0;
                    arr_nxt      = src_arr;
                    cmp_nxt      = src_cmp;
                    tgt_nxt      = src_tgt;
                    step_nxt     = src_step;
                    hold_nxt     = src_hold;
                    scnt_nxt     = '0;
                    if (src_cmp == src_tgt) done_nxt = 1'b1;
                    else                    state_nxt = RAMP;
                end
            end
            STOPPING: if (period_end) begin
                en_nxt    = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        pcnt_nxt = (!en_nxt || !pwm_gen_en || period_end) ? '0 : pcnt + CW'(1);
        tick_nxt = en_nxt && (pcnt_nxt == arr_nxt);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            pwm_gen_en      <= 1'b0;
            counter_arr     <= '0;
            counter_compare <= '0;
            period_tick     <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pcnt            <= '0;
            scnt            <= '0;
            tgt             <= '0;
            step            <= '0;
            hold            <= '0;
            pend_vld        <= 1'b0;
            pend_arr        <= '0;
            pend_tgt        <= '0;
            pend_step       <= '0;
            pend_hold       <= '0;
        end else begin
            state           <= state_nxt;
            pwm_gen_en      <= en_nxt;
            counter_arr     <= arr_nxt;
            counter_compare <= cmp_nxt;
            period_tick     <= tick_nxt;
            busy            <= (state_nxt != IDLE);
            done            <= done_nxt;
            pcnt            <= pcnt_nxt;
            scnt            <= scnt_nxt;
            tgt             <= tgt_nxt;
            step            <= step_nxt;
            hold            <= hold_nxt;
            pend_vld        <= pend_vld_nxt;
            pend_arr        <= pend_arr_nxt;
            pend_tgt        <= pend_tgt_nxt;
            pend_step       <= pend_step_nxt;
            pend_hold       <= pend_hold_nxt;
        end
    end
endmodule
